// File: rtl/rl_pkg.sv
// Shared types and helpers for the epsilon-greedy action scheduler.
// Holds the Q-vector layout, scheduler FSM encoding and LFSR step.
package rl_pkg;

    localparam int Q_W       = 16;
    localparam int N_ACTIONS = 4;
    localparam int EPS_FRAC  = 8;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_OUT    = 3'd4
    } sched_state_t;

    // Element i holds the signed Q8.8 value for action i.
    typedef logic [N_ACTIONS-1:0][Q_W-1:0] q_vec_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    function automatic logic [N_ACTIONS-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/q_argmax.sv
// Combinational signed argmax over the four Q-values.
// Only a strictly greater value replaces the running best, so ties keep the lower index.
module q_argmax
    import rl_pkg::*;
(
    input  q_vec_t     q_vec,
    output logic [1:0] max_idx
);

    logic signed [Q_W-1:0] best_val_s;
    logic [1:0]            best_idx_s;

    // Linear scan keeping the first occurrence of the maximum.
    always_comb begin
        best_val_s = $signed(q_vec[0]);
        best_idx_s = 2'd0;
        for (int i = 1; i < N_ACTIONS; i++) begin
            if ($signed(q_vec[i]) > best_val_s) begin
                best_val_s = $signed(q_vec[i]);
                best_idx_s = i[1:0];
            end else begin
                best_val_s = best_val_s;
            end
        end
    end

    assign max_idx = best_idx_s;

endmodule

// File: rtl/epsilon_greedy_scheduler.sv
// Epsilon-greedy action scheduler: fetches Q-values, explores or exploits, decays epsilon.
// Optional ACT_SEL_STATS_EN adds saturating explore/exploit handshake counters.
module epsilon_greedy_scheduler
    import rl_pkg::*;
#(
    parameter int          STATE_W   = 4,
    parameter int          Q_W       = 16,
    parameter logic [15:0] EPS_INIT  = 16'h0100,
    parameter logic [15:0] EPS_MIN   = 16'h000D,
    parameter int          EPS_SHIFT = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [STATE_W-1:0] req_state,
    input  logic               episode_end,
    output logic               q_rd_en,
    output logic [STATE_W-1:0] q_rd_addr,
    input  logic [4*Q_W-1:0]   q_rd_data,
    output logic               act_valid,
    input  logic               act_ready,
    output logic [3:0]         act_onehot,
    output logic               act_explore,
    output logic [15:0]        epsilon_out
`ifdef ACT_SEL_STATS_EN
    ,
    output logic [15:0]        explore_cnt,
    output logic [15:0]        exploit_cnt
`endif
);

    sched_state_t state_r;
    logic [15:0]  lfsr_r;
    logic [15:0]  eps_r;
    q_vec_t       q_r;

    logic [1:0]   greedy_idx_s;
    logic [1:0]   act_idx_s;
    logic         explore_s;
    logic [15:0]  eps_dec_s;
    logic [15:0]  eps_next_s;

    q_argmax u_argmax (
        .q_vec   (q_r),
        .max_idx (greedy_idx_s)
    );

    // Explore/exploit choice and the next decayed epsilon.
    always_comb begin
        explore_s  = ({{(16-EPS_FRAC){1'b0}}, lfsr_r[EPS_FRAC-1:0]} < eps_r);
        act_idx_s  = greedy_idx_s;
        if (explore_s) begin
            act_idx_s = lfsr_r[EPS_FRAC+1:EPS_FRAC];
        end else begin
            act_idx_s = greedy_idx_s;
        end
        eps_dec_s  = eps_r - (eps_r >> EPS_SHIFT);
        eps_next_s = eps_dec_s;
        if (eps_dec_s < EPS_MIN) begin
            eps_next_s = EPS_MIN;
        end else begin
            eps_next_s = eps_dec_s;
        end
    end

    // Request sequencing FSM with registered handshake and memory outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lfsr_r      <= LFSR_SEED;
            q_r         <= '0;
            req_ready   <= 1'b1;
            q_rd_en     <= 1'b0;
            q_rd_addr   <= '0;
            act_valid   <= 1'b0;
            act_onehot  <= 4'b0000;
            act_explore <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_r   <= ST_FETCH;
                        req_ready <= 1'b0;
                        q_rd_en   <= 1'b1;
                        q_rd_addr <= req_state;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    q_rd_en <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    q_r     <= q_vec_t'(q_rd_data);
                    state_r <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    act_onehot  <= idx_to_onehot(act_idx_s);
                    act_explore <= explore_s;
                    lfsr_r      <= lfsr_step(lfsr_r);
                    act_valid   <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (act_ready) begin
                        act_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_OUT;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    q_rd_en   <= 1'b0;
                    act_valid <= 1'b0;
                end
            endcase
        end
    end

    // Epsilon decays on every episode_end pulse regardless of FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eps_r <= EPS_INIT;
        end else if (episode_end) begin
            eps_r <= eps_next_s;
        end else begin
            eps_r <= eps_r;
        end
    end

    assign epsilon_out = eps_r;

`ifdef ACT_SEL_STATS_EN
    // Saturating counts of accepted explore and exploit actions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            explore_cnt <= 16'h0000;
            exploit_cnt <= 16'h0000;
        end else if (act_valid && act_ready) begin
            if (act_explore) begin
                explore_cnt <= (explore_cnt == 16'hFFFF) ? explore_cnt : explore_cnt + 16'd1;
            end else begin
                exploit_cnt <= (exploit_cnt == 16'hFFFF) ? exploit_cnt : exploit_cnt + 16'd1;
            end
        end else begin
            explore_cnt <= explore_cnt;
            exploit_cnt <= exploit_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_epsilon_greedy_scheduler.sv
// Bench for epsilon_greedy_scheduler: instance 0 starts with eps=0 (greedy), instance 1 with eps=1.0.
// Expected actions come from an arithmetic model of epsilon, the LFSR and argmax.
module tb_epsilon_greedy_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [3:0]  req_state   [2];
    logic        episode_end [2];
    logic        q_rd_en     [2];
    logic [3:0]  q_rd_addr   [2];
    logic [63:0] q_rd_data   [2];
    logic        act_valid   [2];
    logic        act_ready   [2];
    logic [3:0]  act_onehot  [2];
    logic        act_explore [2];
    logic [15:0] epsilon_out [2];
`ifdef ACT_SEL_STATS_EN
    logic [15:0] explore_cnt [2];
    logic [15:0] exploit_cnt [2];
`endif

    logic [63:0] qmem [2][16];

    int          n_cmp = 0;
    int          n_err = 0;
    int          eps_m  [2];
    logic [15:0] lfsr_m [2];
    int          nexp_m [2];
    int          nexl_m [2];

    always #5 clk = ~clk;

    epsilon_greedy_scheduler #(.EPS_INIT(16'h0000)) u_dut_greedy (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_state(req_state[0]),
        .episode_end(episode_end[0]),
        .q_rd_en(q_rd_en[0]), .q_rd_addr(q_rd_addr[0]), .q_rd_data(q_rd_data[0]),
        .act_valid(act_valid[0]), .act_ready(act_ready[0]), .act_onehot(act_onehot[0]),
        .act_explore(act_explore[0]), .epsilon_out(epsilon_out[0])
`ifdef ACT_SEL_STATS_EN
        , .explore_cnt(explore_cnt[0]), .exploit_cnt(exploit_cnt[0])
`endif
    );

    epsilon_greedy_scheduler u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_state(req_state[1]),
        .episode_end(episode_end[1]),
        .q_rd_en(q_rd_en[1]), .q_rd_addr(q_rd_addr[1]), .q_rd_data(q_rd_data[1]),
        .act_valid(act_valid[1]), .act_ready(act_ready[1]), .act_onehot(act_onehot[1]),
        .act_explore(act_explore[1]), .epsilon_out(epsilon_out[1])
`ifdef ACT_SEL_STATS_EN
        , .explore_cnt(explore_cnt[1]), .exploit_cnt(exploit_cnt[1])
`endif
    );

    // Q-table RAM model: one-cycle latency, garbage when not read.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (q_rd_en[d]) q_rd_data[d] <= qmem[d][q_rd_addr[d]];
            else            q_rd_data[d] <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    function automatic int ref_argmax(input logic [63:0] q);
        shortint v [4];
        int best;
        for (int i = 0; i < 4; i++) v[i] = shortint'(q[16*i +: 16]);
        best = 0;
        for (int i = 1; i < 4; i++) if (v[i] > v[best]) best = i;
        return best;
    endfunction

    function automatic int ref_decay(input int e);
        int r;
        r = e - (e / 32);
        return (r < 13) ? 13 : r;
    endfunction

    function automatic logic [63:0] rand_q();
        logic [63:0] r;
        int t;
        for (int i = 0; i < 4; i++) begin
            t = int'($urandom_range(0, 7)) - 4;
            r[16*i +: 16] = t[15:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        eps_m[0] = 0;    eps_m[1] = 256;
        lfsr_m[0] = 16'hACE1; lfsr_m[1] = 16'hACE1;
        nexp_m[0] = 0; nexp_m[1] = 0; nexl_m[0] = 0; nexl_m[1] = 0;
    endtask

    // Expected decision from the current model state, then advance the model.
    task automatic model_decide(input int d, input logic [63:0] q, output logic [3:0] oh, output bit ex);
        int low, idx;
        low = int'(lfsr_m[d] % 256);
        ex  = (low < eps_m[d]);
        idx = ex ? int'((lfsr_m[d] / 256) % 4) : ref_argmax(q);
        oh  = 4'(1 << idx);
        if (ex) nexp_m[d]++; else nexl_m[d]++;
        lfsr_m[d] = (lfsr_m[d] % 2 == 1) ? ((lfsr_m[d] / 2) ^ 16'hB400) : (lfsr_m[d] / 2);
    endtask

    // Drive one request through to its handshake; returns what was observed.
    task automatic run_request(input int d, input logic [3:0] st, input int hold, input bit pulse,
                               output logic [3:0] oh, output bit ex, output int n,
                               output bit fetch_ok, output bit hold_ok);
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        req_valid[d] = 1'b1; req_state[d] = st;
        @(negedge clk);
        req_valid[d] = 1'b0;
        fetch_ok = (q_rd_en[d] === 1'b1) && (q_rd_addr[d] === st);
        n = 0;
        while (act_valid[d] !== 1'b1 && n < 20) begin
            episode_end[d] = pulse && (n == 2);
            @(negedge clk);
            n++;
        end
        episode_end[d] = 1'b0;
        oh = act_onehot[d]; ex = act_explore[d]; hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (act_valid[d] !== 1'b1 || act_onehot[d] !== oh || act_explore[d] !== ex ||
                req_ready[d] !== 1'b0 || q_rd_en[d] !== 1'b0) hold_ok = 1'b0;
        end
        act_ready[d] = 1'b1;
        @(negedge clk);
        act_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (req_ready[d] !== 1'b1 || q_rd_en[d] !== 1'b0 || q_rd_addr[d] !== 4'h0 ||
                act_valid[d] !== 1'b0 || act_onehot[d] !== 4'b0000 || act_explore[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got rr=%b en=%b addr=%h av=%b oh=%b ex=%b want 1 0 0 0 0000 0",
                         d, req_ready[d], q_rd_en[d], q_rd_addr[d], act_valid[d], act_onehot[d], act_explore[d]);
            end
            n_cmp++;
            if (epsilon_out[d] !== 16'(eps_m[d])) begin
                n_err++;
                $display("FAIL reset_epsilon[%0d]: got %h want %h", d, epsilon_out[d], 16'(eps_m[d]));
            end
        end
    endtask

    task automatic check_greedy(input string name, input logic [3:0] st, input logic [63:0] q, input logic [3:0] want);
        logic [3:0] oh, exp_oh; bit ex, exp_ex, fok, hok; int n;
        qmem[0][st] = q;
        model_decide(0, q, exp_oh, exp_ex);
        run_request(0, st, 0, 1'b0, oh, ex, n, fok, hok);
        n_cmp++;
        if (oh !== want || ex !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got oh=%b ex=%b want oh=%b ex=0", name, oh, ex, want);
        end
        n_cmp++;
        if (n !== 3 || !fok) begin
            n_err++;
            $display("FAIL %s_timing: got latency=%0d fetch_ok=%0b want 3 1", name, n, fok);
        end
    endtask

    task automatic test_greedy();
        check_greedy("greedy_max3", 4'd5, 64'h000C_0001_0002_0003, 4'b1000);
        check_greedy("greedy_neg_tie", 4'd9, 64'hFFFE_FFFE_FFFF_FFFF, 4'b0001);
        check_greedy("greedy_all_zero", 4'd15, 64'h0000_0000_0000_0000, 4'b0001);
        for (int k = 0; k < 12; k++) begin
            logic [63:0] q;
            q = rand_q();
            check_greedy("greedy_random", 4'($urandom_range(0, 15)), q, 4'(1 << ref_argmax(q)));
        end
    endtask

    task automatic test_floor();
        n_cmp++;
        if (epsilon_out[0] !== 16'h0000) begin
            n_err++;
            $display("FAIL eps_below_floor_kept: got %h want 0000", epsilon_out[0]);
        end
        episode_end[0] = 1'b1; @(negedge clk); episode_end[0] = 1'b0;
        eps_m[0] = ref_decay(eps_m[0]);
        n_cmp++;
        if (epsilon_out[0] !== 16'h000D) begin
            n_err++;
            $display("FAIL eps_first_decay_floor: got %h want 000D", epsilon_out[0]);
        end
    endtask

    task automatic test_explore();
        logic [3:0] oh, exp_oh, st; bit ex, exp_ex, fok, hok; int n;
        for (int k = 0; k < 20; k++) begin
            st = 4'($urandom_range(0, 15));
            qmem[1][st] = rand_q();
            model_decide(1, qmem[1][st], exp_oh, exp_ex);
            run_request(1, st, 0, 1'b0, oh, ex, n, fok, hok);
            n_cmp++;
            if (oh !== exp_oh || ex !== 1'b1 || exp_ex !== 1'b1) begin
                n_err++;
                $display("FAIL explore[%0d]: got oh=%b ex=%b want oh=%b ex=1", k, oh, ex, exp_oh);
            end
            n_cmp++;
            if (n !== 3 || !fok) begin
                n_err++;
                $display("FAIL explore_timing[%0d]: got latency=%0d fetch_ok=%0b want 3 1", k, n, fok);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] oh, exp_oh; bit ex, exp_ex, fok, hok; int n;
        qmem[1][4'd3] = rand_q();
        model_decide(1, qmem[1][4'd3], exp_oh, exp_ex);
        run_request(1, 4'd3, 10, 1'b0, oh, ex, n, fok, hok);
        n_cmp++;
        if (!hok || oh !== exp_oh || ex !== exp_ex) begin
            n_err++;
            $display("FAIL backpressure_hold: got stable=%0b oh=%b ex=%b want 1 %b %b", hok, oh, ex, exp_oh, exp_ex);
        end
        n_cmp++;
        if (act_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_release: got av=%b rr=%b want 0 1", act_valid[1], req_ready[1]);
        end
    endtask

    task automatic test_decay_steps();
        logic [15:0] want [2];
        want[0] = 16'h00F8; want[1] = 16'h00F1;
        for (int k = 0; k < 2; k++) begin
            episode_end[1] = 1'b1; @(negedge clk); episode_end[1] = 1'b0;
            eps_m[1] = ref_decay(eps_m[1]);
            n_cmp++;
            if (epsilon_out[1] !== want[k]) begin
                n_err++;
                $display("FAIL decay_step%0d: got %h want %h", k + 1, epsilon_out[1], want[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_decide_pulse();
        logic [3:0] oh, exp_oh, st; bit ex, exp_ex, fok, hok; int n;
        for (int k = 0; k < 30; k++) begin
            st = 4'($urandom_range(0, 15));
            qmem[1][st] = rand_q();
            model_decide(1, qmem[1][st], exp_oh, exp_ex);
            eps_m[1] = ref_decay(eps_m[1]);
            run_request(1, st, 0, 1'b1, oh, ex, n, fok, hok);
            n_cmp++;
            if (oh !== exp_oh || ex !== exp_ex || n !== 3) begin
                n_err++;
                $display("FAIL decide_pulse[%0d]: got oh=%b ex=%b lat=%0d want oh=%b ex=%b lat=3",
                         k, oh, ex, n, exp_oh, exp_ex);
            end
            n_cmp++;
            if (epsilon_out[1] !== 16'(eps_m[1])) begin
                n_err++;
                $display("FAIL decide_pulse_eps[%0d]: got %h want %h", k, epsilon_out[1], 16'(eps_m[1]));
            end
        end
`ifdef ACT_SEL_STATS_EN
        n_cmp++;
        if (explore_cnt[1] !== 16'(nexp_m[1]) || exploit_cnt[1] !== 16'(nexl_m[1])) begin
            n_err++;
            $display("FAIL stats_counts: got %0d/%0d want %0d/%0d", explore_cnt[1], exploit_cnt[1], nexp_m[1], nexl_m[1]);
        end
`endif
    endtask

    task automatic test_back_to_back_decay();
        episode_end[1] = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            eps_m[1] = ref_decay(eps_m[1]);
            n_cmp++;
            if (epsilon_out[1] !== 16'(eps_m[1]) || epsilon_out[1] < 16'h000D) begin
                n_err++;
                $display("FAIL decay_chain[%0d]: got %h want %h", k, epsilon_out[1], 16'(eps_m[1]));
            end
        end
        episode_end[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] oh, exp_oh; bit ex, exp_ex, fok, hok; int n;
        req_valid[1] = 1'b1; req_state[1] = 4'd7;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (act_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 || q_rd_en[1] !== 1'b0 || epsilon_out[1] !== 16'h0100) begin
            n_err++;
            $display("FAIL reset_mid: got av=%b rr=%b en=%b eps=%h want 0 1 0 0100",
                     act_valid[1], req_ready[1], q_rd_en[1], epsilon_out[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        qmem[1][4'd7] = rand_q();
        model_decide(1, qmem[1][4'd7], exp_oh, exp_ex);
        run_request(1, 4'd7, 0, 1'b0, oh, ex, n, fok, hok);
        n_cmp++;
        if (oh !== exp_oh || ex !== exp_ex) begin
            n_err++;
            $display("FAIL reset_mid_seed: got oh=%b ex=%b want oh=%b ex=%b", oh, ex, exp_oh, exp_ex);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_state[d] = 4'h0; episode_end[d] = 1'b0; act_ready[d] = 1'b0;
            for (int s = 0; s < 16; s++) qmem[d][s] = 64'h0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_greedy();
        test_floor();
        test_explore();
        test_backpressure();
        test_decay_steps();
        test_decide_pulse();
        test_back_to_back_decay();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
